mcs_ctrl: RTL and testbench
===========================

MCS_CTRL -- requirements
Module: mcs_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, word width in bits (W >= 2).
REQ-002 SHALL have port t_clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port r  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream word available.
REQ-005 SHALL have port in_ready  output  1  block can accept a word.
REQ-006 SHALL have port in_data  input  W  two's-complement operand.
REQ-007 SHALL have port out_valid  output  1  result available.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-009 SHALL have port out_data  output  W  negated operand (-in_data mod 2^W).
REQ-010 SHALL have port out_ovf  output  1  operand was the most-negative value (1 followed by W-1 zeros).
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port cmp_clr  output  1  active-high clear to the external serial complementer.
REQ-013 SHALL have port cmp_x  output  1  serial bit to the complementer, LSB first.
REQ-014 SHALL have port cmp_y  input  1  complementer output; a combinational function of cmp_x and complementer state, valid in the same cycle.

Function
REQ-015 SHALL implement the FSM states IDLE, CLR, SHIFT and DONE.
REQ-016 IDLE: in_ready=1; when in_valid=1 at an edge, SHALL latch in_data into the shift register, latch out_ovf=(in_data==1<<(W-1)), and go to CLR.
REQ-017 CLR: cmp_clr=1 for exactly one cycle; SHALL clear the bit counter to 0 and go to SHIFT.
REQ-018 SHIFT: cmp_x = shift register bit 0; at each edge SHALL sample cmp_y into the MSB of the result register (result shifts right), shift the operand right, and increment the counter.
REQ-019 SHIFT SHALL last exactly W cycles; at the edge where the counter reaches W-1, SHALL go to DONE.
REQ-020 DONE: out_valid=1 and out_data/out_ovf stable; SHALL hold until out_ready=1 at an edge, then go to IDLE.
REQ-021 in_ready SHALL be 0 in CLR, SHIFT and DONE; in_valid outside IDLE SHALL be ignored.
REQ-022 cmp_clr SHALL be 0 outside CLR; cmp_x SHALL be 0 outside SHIFT.
REQ-023 Latency: acceptance edge E -> out_valid high in the cycle after edge E+W+1; minimum word period W+3 cycles (no IDLE bypass).
REQ-024 The counter SHALL be ceil(log2(W)) bits wide (minimum 1) and SHALL NOT wrap within a word.
REQ-025 out_data SHALL equal the bits collected from cmp_y; the block SHALL NOT compute the negation itself.
REQ-026 Operand 0 SHALL produce out_data=0 with out_ovf=0; the most-negative operand SHALL produce out_data equal to the operand with out_ovf=1.
REQ-027 out_valid held without out_ready SHALL keep all outputs unchanged indefinitely.

Reset
REQ-028 r=0 SHALL immediately force state=IDLE, counter=0, shift and result registers=0, out_valid=0, out_ovf=0, out_data=0, cmp_clr=0, cmp_x=0, busy=0; in_ready SHALL be 1.
REQ-029 Reset asserted mid-SHIFT or in DONE SHALL discard the word with no out_valid pulse; after release, the first edge with in_valid=1 SHALL accept a new word normally.

Verification (W=8, complementer attached)
REQ-030 in_data=0x05, out_ready=1 -> cmp_x sequence 1,0,1,0,0,0,0,0; out_data=0xFB, out_ovf=0; out_valid first high in the cycle after edge E+9.
REQ-031 in_data=0x00 -> out_data=0x00, out_ovf=0; in_data=0x01 -> out_data=0xFF.
REQ-032 in_data=0x80 -> out_data=0x80, out_ovf=1.
REQ-033 Result 0x3A (in_data=0xC6) with out_ready=0 for 5 cycles -> out_valid, out_data and in_ready=0 held stable; single transfer on out_ready=1; then IDLE.
REQ-034 r pulsed low during SHIFT bit 4 -> all outputs at reset values at once, no out_valid; the next word 0x7F -> 0x81.
REQ-035 in_valid held high continuously with 3 words -> exactly one accept per W+3 cycles, cmp_clr pulses exactly once per word, results emitted in order.

Source files
------------

// File: rtl/mcs_ctrl_if.sv
// rtl/mcs_ctrl_if.sv - operand/result handshake bundle for mcs_ctrl
//
// Signals:
//   in_valid  : upstream word available
//   in_ready  : block can accept a word
//   in_data   : W-bit two's-complement operand
//   out_valid : result available
//   out_ready : downstream accepts the result
//   out_data  : W-bit negated operand, as collected from the complementer
//   out_ovf   : operand was the most-negative value
// Modports:
//   master : the upstream/downstream environment side
//   slave  : the mcs_ctrl side
interface mcs_ctrl_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ovf
  );
endinterface

// File: rtl/mcs_ctrl.sv
// rtl/mcs_ctrl.sv - serial two's-complement negation sequencer driving an external complementer
//
// Ports:
//   t_clock : sole clock, rising edge
//   r       : asynchronous active-low reset
//   io      : mcs_ctrl_if.slave (in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_ovf)
//   busy    : high whenever the sequencer is not idle
//   cmp_clr : one-cycle clear pulse to the external serial complementer
//   cmp_x   : serial operand bit to the complementer, LSB first
//   cmp_y   : complementer output, combinational in cmp_x, sampled every shift cycle
module mcs_ctrl #(
  parameter int W = 8
) (
  input  logic         t_clock,
  input  logic         r,
  mcs_ctrl_if.slave    io,
  output logic         busy,
  output logic         cmp_clr,
  output logic         cmp_x,
  input  logic         cmp_y
);

  // Counter only needs to reach W-1; keep at least one bit.
  localparam int CW = ($clog2(W) < 1) ? 1 : $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sh;
  logic [W-1:0]  res;
  logic          ovf;
  logic          in_ready_c;
  logic          out_valid_c;

  // State register.
  always_ff @(posedge t_clock or negedge r) begin
    if (!r) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    cmp_clr     = 1'b0;
    cmp_x       = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        in_ready_c = 1'b1;
        if (io.in_valid) begin
          state_nxt = CLR;
        end
      end
      CLR: begin
        cmp_clr   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        cmp_x = sh[0];
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (io.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: operand shifts out LSB first while the complementer's answer
  // enters at the MSB, so after W shifts the first answer bit sits at bit 0.
  always_ff @(posedge t_clock or negedge r) begin
    if (!r) begin
      cnt <= '0;
      sh  <= '0;
      res <= '0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            sh  <= io.in_data;
            res <= '0;
            ovf <= (io.in_data == MOST_NEG);
          end
        end
        CLR: begin
          cnt <= '0;
        end
        SHIFT: begin
          res <= {cmp_y, res[W-1:1]};
          sh  <= {1'b0, sh[W-1:1]};
          // Hold at the last value instead of wrapping on the final bit.
          if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = out_valid_c;
  assign io.out_data  = res;
  assign io.out_ovf   = ovf;

endmodule

// File: tb/tb_mcs_ctrl.sv
// tb/tb_mcs_ctrl.sv - self-checking bench for mcs_ctrl with an attached serial complementer
module tb_mcs_ctrl;
  localparam int W = 8;

  logic t_clock = 1'b0;
  logic r = 1'b0;
  logic busy;
  logic cmp_clr;
  logic cmp_x;
  logic cmp_y;

  mcs_ctrl_if #(.W(W)) io ();

  mcs_ctrl #(.W(W)) dut (
    .t_clock (t_clock),
    .r       (r),
    .io      (io),
    .busy    (busy),
    .cmp_clr (cmp_clr),
    .cmp_x   (cmp_x),
    .cmp_y   (cmp_y)
  );

  always #5 t_clock = ~t_clock;

  // Serial two's-complement negator: pass bits up to and including the
  // first 1, invert every bit after it.
  logic seen;
  always @(posedge t_clock or negedge r) begin
    if (!r)           seen <= 1'b0;
    else if (cmp_clr) seen <= 1'b0;
    else if (cmp_x)   seen <= 1'b1;
  end
  assign cmp_y = cmp_x ^ seen;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: -1 idle, 0 clear cycle, 1..W shift cycles, W+1 result held.
  int           m_phase = -1;
  logic [W-1:0] m_op = '0;
  logic [W-1:0] m_neg;
  logic         m_ovf;
  assign m_neg = W'(0) - m_op;
  assign m_ovf = (m_op == W'(1 << (W - 1)));

  always @(posedge t_clock or negedge r) begin
    if (!r) begin
      m_phase <= -1;
      m_op    <= '0;
    end else if (m_phase < 0) begin
      if (io.in_valid) begin
        m_op    <= io.in_data;
        m_phase <= 0;
      end
    end else if (m_phase <= W) begin
      m_phase <= m_phase + 1;
    end else if (io.out_ready) begin
      m_phase <= -1;
    end
  end

  always @(negedge t_clock) begin
    chk("m_in_ready",  io.in_ready,  m_phase < 0);
    chk("m_busy",      busy,         m_phase >= 0);
    chk("m_cmp_clr",   cmp_clr,      m_phase == 0);
    chk("m_out_valid", io.out_valid, m_phase == W + 1);
    chk("m_cmp_x",     cmp_x,        (m_phase >= 1 && m_phase <= W) ? m_op[m_phase-1] : 1'b0);
    if (m_phase == W + 1) begin
      chk("m_out_data", io.out_data, m_neg);
      chk("m_out_ovf",  io.out_ovf,  m_ovf);
    end
  end

  int cyc = 0;
  always @(posedge t_clock) cyc <= cyc + 1;

  int nclr = 0;
  always @(negedge t_clock) if (cmp_clr) nclr++;

  logic [7:0] got[$];
  always @(posedge t_clock) if (r && io.out_valid && io.out_ready) got.push_back(io.out_data);

  task automatic send_word(input logic [7:0] d, input int hold, input logic [7:0] ed, input logic eovf);
    int t;
    logic [7:0] xs;
    @(negedge t_clock); #1;
    io.in_valid  = 1'b1;
    io.in_data   = d;
    io.out_ready = (hold == 0);
    t = 0;
    while (!io.in_ready && t < 50) begin @(posedge t_clock); #1; t++; end
    chk("accept_wait", t < 50, 1);
    @(posedge t_clock); #1;
    io.in_valid = 1'b0;
    io.in_data  = 8'hA5;
    t  = 0;
    xs = '0;
    while (!io.out_valid && t < 50) begin
      @(posedge t_clock); #1;
      t++;
      if (t >= 1 && t <= W) xs[t-1] = cmp_x;
    end
    chk("latency",   t, W + 1);
    chk("cmp_x_seq", xs, d);
    chk("out_data",  io.out_data, ed);
    chk("out_ovf",   io.out_ovf, eovf);
    for (int i = 0; i < hold; i++) begin
      @(posedge t_clock); #1;
      chk("hold_valid",    io.out_valid, 1);
      chk("hold_data",     io.out_data, ed);
      chk("hold_in_ready", io.in_ready, 0);
    end
    io.out_ready = 1'b1;
    @(posedge t_clock); #1;
    chk("xfer_valid_low", io.out_valid, 0);
    chk("xfer_idle",      io.in_ready, 1);
    io.out_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},  io.in_ready, 1);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_out_valid"}, io.out_valid, 0);
    chk({tag, "_out_data"},  io.out_data, 0);
    chk({tag, "_out_ovf"},   io.out_ovf, 0);
    chk({tag, "_cmp_clr"},   cmp_clr, 0);
    chk({tag, "_cmp_x"},     cmp_x, 0);
  endtask

  logic [7:0] words [3];
  logic [7:0] exps  [3];
  int         acc   [3];

  initial begin
    int t;
    int n0;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.out_ready = 1'b0;
    r = 1'b0;
    repeat (2) @(posedge t_clock);
    @(negedge t_clock); #1;
    check_reset_values("por");
    r = 1'b1;

    send_word(8'h05, 0, 8'hFB, 1'b0);
    send_word(8'h00, 0, 8'h00, 1'b0);
    send_word(8'h01, 0, 8'hFF, 1'b0);
    send_word(8'h80, 0, 8'h80, 1'b1);
    send_word(8'hC6, 5, 8'h3A, 1'b0);

    // Reset in the shift cycle carrying operand bit 4.
    @(negedge t_clock); #1;
    io.in_valid  = 1'b1;
    io.in_data   = 8'h3C;
    io.out_ready = 1'b1;
    t = 0;
    while (!io.in_ready && t < 50) begin @(posedge t_clock); #1; t++; end
    chk("rst_accept_wait", t < 50, 1);
    @(posedge t_clock); #1;
    io.in_valid = 1'b0;
    repeat (5) @(posedge t_clock);
    #1;
    chk("rst_busy_before", busy, 1);
    r = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge t_clock); #1;
    r = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge t_clock); #1;
      chk("rst_no_valid", io.out_valid, 0);
    end
    send_word(8'h7F, 0, 8'h81, 1'b0);

    // Back-to-back words with in_valid held high.
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    exps[0]  = 8'hEF; exps[1]  = 8'hDE; exps[2]  = 8'hCD;
    got.delete();
    n0 = nclr;
    @(negedge t_clock); #1;
    io.out_ready = 1'b1;
    io.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      while (!io.in_ready && t < 50) begin @(posedge t_clock); #1; t++; end
      chk("stream_accept_wait", t < 50, 1);
      io.in_data = words[k];
      @(posedge t_clock); #1;
      acc[k] = cyc;
    end
    io.in_valid = 1'b0;
    t = 0;
    while (busy && t < 50) begin @(posedge t_clock); #1; t++; end
    chk("stream_drain", t < 50, 1);
    chk("stream_period_01", acc[1] - acc[0], W + 3);
    chk("stream_period_12", acc[2] - acc[1], W + 3);
    chk("stream_clr_pulses", nclr - n0, 3);
    chk("stream_count", got.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("stream_result", (k < got.size()) ? got[k] : 8'hXX, exps[k]);
    end
    io.out_ready = 1'b0;

    repeat (3) @(posedge t_clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
